// File: rtl/ccsds_cube_feeder_if.sv
// Raw-data word stream from the cube feeder to the compressor core.
interface ccsds_cube_feeder_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned LANE_W = 16
);
    logic                    cmprs_rdf_data_ready;
    logic                    cmprs_rdf_data_valid;
    logic [LANES*LANE_W-1:0] cmprs_rdf_rd_data;
    logic                    cmprs_rdf_data_end;
    logic [LANES-1:0]        lane_mask;

    modport master (
        input  cmprs_rdf_data_ready,
        output cmprs_rdf_data_valid,
        output cmprs_rdf_rd_data,
        output cmprs_rdf_data_end,
        output lane_mask
    );

    modport slave (
        output cmprs_rdf_data_ready,
        input  cmprs_rdf_data_valid,
        input  cmprs_rdf_rd_data,
        input  cmprs_rdf_data_end,
        input  lane_mask
    );
endinterface

// File: rtl/ccsds_cube_feeder.sv
// Cube-sample source: issues cfg_en, then walks an X*Y*Z cube in BSQ/BIL/BIP order
// and streams LANES packed samples per word over a valid/ready handshake.
module ccsds_cube_feeder #(
    parameter int unsigned X_LEN    = 11,
    parameter int unsigned Y_LEN    = 6,
    parameter int unsigned Z_LEN    = 8,
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned LANE_W   = 16,
    parameter int unsigned LANES    = 2,
    parameter int unsigned CFG_GAP  = 4
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [X_LEN-1:0]    X_max_in,
    input  logic [Y_LEN-1:0]    Y_max_in,
    input  logic [Z_LEN-1:0]    Z_max_in,
    input  logic [1:0]          mode_in,
    input  logic [SAMPLE_W-1:0] seed,
    output logic [X_LEN-1:0]    X_max,
    output logic [Z_LEN-1:0]    Z_max,
    output logic [1:0]          mode,
    output logic                cfg_en,
    ccsds_cube_feeder_if.master rdf,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);
    localparam int unsigned GAP_W = (CFG_GAP > 1) ? $clog2(CFG_GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_GAP, S_STREAM, S_DONE} state_e;
    typedef enum logic [1:0] {M_BSQ = 2'd0, M_BIL = 2'd1, M_BIP = 2'd2, M_RSVD = 2'd3} mode_e;

    state_e                  state_q;
    mode_e                   mode_q;
    logic [GAP_W-1:0]        gap_q;
    logic [X_LEN-1:0]        xm_q;
    logic [Y_LEN-1:0]        ym_q;
    logic [Z_LEN-1:0]        zm_q;
    logic [SAMPLE_W-1:0]     seed_q;
    logic [X_LEN-1:0]        pos_x_q, nx_d;
    logic [Y_LEN-1:0]        pos_y_q, ny_d;
    logic [Z_LEN-1:0]        pos_z_q, nz_d;
    logic                    cfg_en_q, valid_q, end_q, busy_q, done_q, cfg_err_q;
    logic [LANES*LANE_W-1:0] data_q, word_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic                    end_d;

    function automatic logic [SAMPLE_W-1:0] sample_at(
        input logic [SAMPLE_W-1:0] s,
        input logic [X_LEN-1:0]    x,
        input logic [Y_LEN-1:0]    y,
        input logic [Z_LEN-1:0]    z
    );
        return s + SAMPLE_W'(x) + (SAMPLE_W'(y) << 1) + (SAMPLE_W'(z) << 2);
    endfunction

    // pos_*_q points at the first sample of the next word; build it plus the follow-on position.
    always_comb begin
        word_d = '0;
        mask_d = '0;
        end_d  = 1'b0;
        nx_d   = pos_x_q;
        ny_d   = pos_y_q;
        nz_d   = pos_z_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (!end_d) begin
                word_d[l*LANE_W +: LANE_W] = LANE_W'(sample_at(seed_q, nx_d, ny_d, nz_d));
                mask_d[l] = 1'b1;
                if (nx_d == xm_q && ny_d == ym_q && nz_d == zm_q) begin
                    end_d = 1'b1;
                end else begin
                    case (mode_q)
                        M_BIL: begin
                            if (nx_d != xm_q) nx_d = nx_d + X_LEN'(1);
                            else begin
                                nx_d = '0;
                                if (nz_d != zm_q) nz_d = nz_d + Z_LEN'(1);
                                else begin
                                    nz_d = '0;
                                    ny_d = ny_d + Y_LEN'(1);
                                end
                            end
                        end
                        M_BIP: begin
                            if (nz_d != zm_q) nz_d = nz_d + Z_LEN'(1);
                            else begin
                                nz_d = '0;
                                if (nx_d != xm_q) nx_d = nx_d + X_LEN'(1);
                                else begin
                                    nx_d = '0;
                                    ny_d = ny_d + Y_LEN'(1);
                                end
                            end
                        end
                        default: begin
                            if (nx_d != xm_q) nx_d = nx_d + X_LEN'(1);
                            else begin
                                nx_d = '0;
                                if (ny_d != ym_q) ny_d = ny_d + Y_LEN'(1);
                                else begin
                                    ny_d = '0;
                                    nz_d = nz_d + Z_LEN'(1);
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= M_BSQ;
            gap_q     <= '0;
            xm_q      <= '0;
            ym_q      <= '0;
            zm_q      <= '0;
            seed_q    <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            pos_z_q   <= '0;
            cfg_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            data_q    <= '0;
            mask_q    <= '0;
        end else begin
            cfg_en_q  <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (mode_in == M_RSVD) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            xm_q     <= X_max_in;
                            ym_q     <= Y_max_in;
                            zm_q     <= Z_max_in;
                            mode_q   <= mode_e'(mode_in);
                            seed_q   <= seed;
                            cfg_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= S_CFG;
                        end
                    end
                end
                S_CFG: begin
                    gap_q   <= '0;
                    pos_x_q <= '0;
                    pos_y_q <= '0;
                    pos_z_q <= '0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(CFG_GAP - 1)) begin
                        valid_q <= 1'b1;
                        data_q  <= word_d;
                        mask_q  <= mask_d;
                        end_q   <= end_d;
                        pos_x_q <= nx_d;
                        pos_y_q <= ny_d;
                        pos_z_q <= nz_d;
                        state_q <= S_STREAM;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                S_STREAM: begin
                    if (valid_q && rdf.cmprs_rdf_data_ready) begin
                        if (end_q) begin
                            valid_q <= 1'b0;
                            end_q   <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            data_q  <= word_d;
                            mask_q  <= mask_d;
                            end_q   <= end_d;
                            pos_x_q <= nx_d;
                            pos_y_q <= ny_d;
                            pos_z_q <= nz_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Abort overrides whatever the state above decided, including a same-cycle transfer.
            if (abort && (state_q == S_CFG || state_q == S_GAP || state_q == S_STREAM)) begin
                valid_q <= 1'b0;
                end_q   <= 1'b0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
            end
        end
    end

    assign X_max                    = xm_q;
    assign Z_max                    = zm_q;
    assign mode                     = mode_q;
    assign cfg_en                   = cfg_en_q;
    assign busy                     = busy_q;
    assign done                     = done_q;
    assign cfg_err                  = cfg_err_q;
    assign rdf.cmprs_rdf_data_valid = valid_q;
    assign rdf.cmprs_rdf_rd_data    = data_q;
    assign rdf.cmprs_rdf_data_end   = end_q;
    assign rdf.lane_mask            = mask_q;
endmodule

// File: tb/tb_ccsds_cube_feeder.sv
// Scoreboard bench for ccsds_cube_feeder: an independent cube walker predicts every word.
module tb_ccsds_cube_feeder;
    logic        sclk = 1'b0;
    logic        rst, start, abort;
    logic [10:0] X_max_in;
    logic [5:0]  Y_max_in;
    logic [7:0]  Z_max_in;
    logic [1:0]  mode_in;
    logic [11:0] seed;
    logic [10:0] X_max;
    logic [7:0]  Z_max;
    logic [1:0]  mode;
    logic        cfg_en, busy, done, cfg_err;

    int n_chk  = 0;
    int n_pass = 0;
    logic [34:0] exp_q[$];

    ccsds_cube_feeder_if #(.LANES(2), .LANE_W(16)) rdf ();

    ccsds_cube_feeder #(
        .X_LEN(11), .Y_LEN(6), .Z_LEN(8), .SAMPLE_W(12),
        .LANE_W(16), .LANES(2), .CFG_GAP(4)
    ) dut (
        .sclk(sclk), .rst(rst), .start(start), .abort(abort),
        .X_max_in(X_max_in), .Y_max_in(Y_max_in), .Z_max_in(Z_max_in),
        .mode_in(mode_in), .seed(seed),
        .X_max(X_max), .Z_max(Z_max), .mode(mode), .cfg_en(cfg_en),
        .rdf(rdf),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [60:0] all_outs();
        return {rdf.cmprs_rdf_data_valid, rdf.cmprs_rdf_data_end, rdf.cmprs_rdf_rd_data,
                rdf.lane_mask, busy, done, cfg_en, cfg_err, X_max, Z_max, mode};
    endfunction

    task automatic push_cube(input logic [1:0] m, input int xm, input int ym, input int zm,
                             input logic [11:0] sd);
        int smp[$];
        logic [31:0] d;
        logic [1:0]  mk;
        logic        e;
        if (m == 2'd0) begin
            for (int z = 0; z <= zm; z++) for (int y = 0; y <= ym; y++) for (int x = 0; x <= xm; x++)
                smp.push_back((int'(sd) + x + 2*y + 4*z) % 4096);
        end else if (m == 2'd1) begin
            for (int y = 0; y <= ym; y++) for (int z = 0; z <= zm; z++) for (int x = 0; x <= xm; x++)
                smp.push_back((int'(sd) + x + 2*y + 4*z) % 4096);
        end else begin
            for (int y = 0; y <= ym; y++) for (int x = 0; x <= xm; x++) for (int z = 0; z <= zm; z++)
                smp.push_back((int'(sd) + x + 2*y + 4*z) % 4096);
        end
        for (int i = 0; i < smp.size(); i += 2) begin
            d  = '0;
            mk = '0;
            for (int l = 0; l < 2; l++) begin
                if (i + l < smp.size()) begin
                    d[l*16 +: 16] = 16'(smp[i+l]);
                    mk[l] = 1'b1;
                end
            end
            e = (i + 2 >= smp.size());
            exp_q.push_back({e, mk, d});
        end
    endtask

    task automatic run_cube(input logic [1:0] m, input int xm, input int ym, input int zm,
                            input logic [11:0] sd, input int stall_word, input int stall_len,
                            input bit do_abort, input bit poke_start,
                            output logic [31:0] w0, output logic [31:0] w1);
        int cyc, cfg_cyc, first_v, ncfg, nwords, nend, nerr, stall_cnt, nexp;
        bit prev_stall, got_done, abort_chk;
        logic [34:0] obs, prev_obs, exp_w;
        w0 = '0; w1 = '0; cyc = 0; cfg_cyc = -100; first_v = -1; ncfg = 0; nwords = 0;
        nend = 0; nerr = 0; stall_cnt = 0; prev_stall = 0; got_done = 0; abort_chk = 0;
        prev_obs = '0;
        push_cube(m, xm, ym, zm, sd);
        nexp = exp_q.size();
        @(negedge sclk);
        X_max_in = 11'(xm); Y_max_in = 6'(ym); Z_max_in = 8'(zm); mode_in = m; seed = sd;
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        while (!got_done && cyc < 2000) begin
            obs = {rdf.cmprs_rdf_data_end, rdf.lane_mask, rdf.cmprs_rdf_rd_data};
            if (cfg_en) begin ncfg++; cfg_cyc = cyc; end
            if (cfg_err) nerr++;
            if (abort_chk) begin
                chk("abort_valid_drop", 64'(rdf.cmprs_rdf_data_valid), 64'(0));
                chk("abort_done", 64'(done), 64'(1));
                abort_chk = 0;
            end
            if (prev_stall)
                chk("stall_hold", 64'({rdf.cmprs_rdf_data_valid, obs}), 64'({1'b1, prev_obs}));
            rdf.cmprs_rdf_data_ready = 1'b1;
            if (rdf.cmprs_rdf_data_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("busy_in_stream", 64'(busy), 64'(1));
                    if (poke_start) begin start = 1'b1; mode_in = 2'd3; X_max_in = '0; end
                end
                if (nwords == stall_word && stall_cnt < stall_len) begin
                    rdf.cmprs_rdf_data_ready = 1'b0;
                    stall_cnt++;
                    if (do_abort && stall_cnt == 2) begin abort = 1'b1; abort_chk = 1; end
                end else if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(nwords + 1), 64'(nexp));
                    nwords++;
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("word", 64'(obs), 64'(exp_w));
                    if (nwords == 0) w0 = obs[31:0];
                    if (nwords == 1) w1 = obs[31:0];
                    if (obs[34]) nend++;
                    nwords++;
                end
            end
            prev_stall = rdf.cmprs_rdf_data_valid && !rdf.cmprs_rdf_data_ready && !abort;
            prev_obs = obs;
            if (done) begin
                got_done = 1;
                chk("done_busy_low", 64'(busy), 64'(0));
                chk("done_valid_low", 64'(rdf.cmprs_rdf_data_valid), 64'(0));
            end
            @(negedge sclk);
            cyc++;
            start = 1'b0; abort = 1'b0; mode_in = m; X_max_in = 11'(xm);
        end
        rdf.cmprs_rdf_data_ready = 1'b1;
        chk("done_seen", 64'(got_done), 64'(1));
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("cfg_en_count", 64'(ncfg), 64'(1));
        chk("first_valid_latency", 64'(first_v - cfg_cyc), 64'(5));
        chk("cfg_err_quiet", 64'(nerr), 64'(0));
        chk("cfg_outputs", 64'({X_max, Z_max, mode}), 64'({11'(xm), 8'(zm), m}));
        if (do_abort) begin
            chk("abort_no_end", 64'(nend), 64'(0));
            exp_q.delete();
        end else begin
            chk("word_count", 64'(nwords), 64'(nexp));
            chk("end_count", 64'(nend), 64'(1));
            chk("queue_drained", 64'(exp_q.size()), 64'(0));
        end
    endtask

    initial begin
        logic [31:0] w0, w1;
        int n, nv;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        X_max_in = '0; Y_max_in = '0; Z_max_in = '0; mode_in = '0; seed = '0;
        rdf.cmprs_rdf_data_ready = 1'b1;
        repeat (3) @(negedge sclk);
        chk("reset_outputs", 64'(all_outs()), 64'(0));
        rst = 1'b0;

        run_cube(2'd0, 3, 1, 1, 12'h000, -1, 0, 0, 1, w0, w1);
        chk("bsq_w0", 64'(w0), 64'(32'h0001_0000));
        chk("bsq_w1", 64'(w1), 64'(32'h0003_0002));

        run_cube(2'd2, 3, 1, 1, 12'h000, -1, 0, 0, 0, w0, w1);
        chk("bip_w0", 64'(w0), 64'(32'h0004_0000));
        chk("bip_w1", 64'(w1), 64'(32'h0005_0001));

        run_cube(2'd0, 2, 0, 0, 12'hFFF, -1, 0, 0, 0, w0, w1);
        chk("odd_w0", 64'(w0), 64'(32'h0000_0FFF));
        chk("odd_w1", 64'(w1), 64'(32'h0000_0001));

        run_cube(2'd1, 3, 1, 1, 12'h005, 2, 3, 0, 0, w0, w1);
        run_cube(2'd0, 3, 1, 1, 12'h000, 4, 6, 1, 0, w0, w1);

        run_cube(2'd0, 0, 0, 0, 12'h123, -1, 0, 0, 0, w0, w1);
        chk("zero_cube_w0", 64'(w0), 64'(32'h0000_0123));

        run_cube(2'd1, 4, 2, 2, 12'h7F0, 3, 2, 0, 0, w0, w1);

        @(negedge sclk);
        mode_in = 2'd3; X_max_in = 11'd9; start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        chk("rsvd_cfg_err_pulse", 64'(cfg_err), 64'(1));
        chk("rsvd_not_busy", 64'(busy), 64'(0));
        @(negedge sclk);
        chk("rsvd_cfg_err_clear", 64'(cfg_err), 64'(0));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (cfg_en || busy || rdf.cmprs_rdf_data_valid) n++;
            @(negedge sclk);
        end
        chk("rsvd_no_run", 64'(n), 64'(0));
        chk("rsvd_cfg_hold", 64'(X_max), 64'(4));

        mode_in = 2'd0; X_max_in = 11'd3; Y_max_in = 6'd1; Z_max_in = 8'd1; seed = '0;
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        nv = 0;
        for (int i = 0; i < 40 && nv < 3; i++) begin
            if (rdf.cmprs_rdf_data_valid) nv++;
            @(negedge sclk);
        end
        chk("rst_reached_stream", 64'(nv), 64'(3));
        rst = 1'b1;
        @(negedge sclk);
        chk("rst_mid_outputs", 64'(all_outs()), 64'(0));
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || rdf.cmprs_rdf_data_valid || rdf.cmprs_rdf_data_end || cfg_en) n++;
            @(negedge sclk);
        end
        chk("rst_quiet_after", 64'(n), 64'(0));

        run_cube(2'd2, 1, 2, 3, 12'hABC, 1, 1, 0, 0, w0, w1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
